// File: rtl/cpu0_oci_pkg.sv
// Shared types and constants for the CPU0 OCI direct-compressed-trace path.
//   DCT_BUF_W / DCT_CNT_W / ATOM_W / DCT_MAX_ATOMS : accumulator geometry
//   dct_state_e : sequencer states
//   dct_frame_t : one frame as handed to trace memory {count, buffer}
//   pack_atom   : writes one atom into the slot selected by the atom count
package cpu0_oci_pkg;

   localparam int DCT_BUF_W     = 30;
   localparam int DCT_CNT_W     = 4;
   localparam int ATOM_W        = 2;
   localparam int DCT_MAX_ATOMS = 15;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PACK      = 3'd1,
      ST_END_FLUSH = 3'd2,
      ST_END_DRAIN = 3'd3,
      ST_ENDED     = 3'd4
   } dct_state_e;

   typedef struct packed {
      logic [DCT_CNT_W-1:0] count;
      logic [DCT_BUF_W-1:0] buffer;
   } dct_frame_t;

   // Slot i occupies bits [2i+1:2i]; a loop over fixed slots keeps the
   // insert free of variable part-selects.
   function automatic logic [DCT_BUF_W-1:0] pack_atom(
      input logic [DCT_BUF_W-1:0] acc_in,
      input logic [DCT_CNT_W-1:0] cnt,
      input logic [ATOM_W-1:0]    atom
   );
      logic [DCT_BUF_W-1:0] r;
      r = acc_in;
      for (int i = 0; i < DCT_MAX_ATOMS; i++) begin
         if (cnt == DCT_CNT_W'(i)) r[ATOM_W*i +: ATOM_W] = atom;
      end
      return r;
   endfunction

endpackage

// File: rtl/cpu0_oci_dct_holdreg.sv
// Single-entry valid/ready holding register for completed DCT frames.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   load_valid    : a frame is being handed over this cycle
//   load_frame    : the frame being handed over
//   load_ready    : register is empty or is being emptied this cycle
//   frame_valid   : frame offered downstream
//   frame         : held frame, stable while frame_valid && !frame_ready
//   frame_ready   : downstream accepts the frame
module cpu0_oci_dct_holdreg
   import cpu0_oci_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load_valid,
   input  dct_frame_t load_frame,
   output logic       load_ready,
   output logic       frame_valid,
   output dct_frame_t frame,
   input  logic       frame_ready
);

   // A new frame may land on the same edge the old one leaves.
   assign load_ready = !frame_valid || frame_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_valid <= 1'b0;
         frame       <= '0;
      end else if (load_valid && load_ready) begin
         frame_valid <= 1'b1;
         frame       <= load_frame;
      end else if (frame_ready) begin
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu0_oci_dct_ctrl.sv
// Sequencer for the CPU0 OCI direct-compressed-trace path.
// Packs 2-bit atoms into a 30-bit accumulator (up to 15 atoms) and moves
// full or flushed accumulators into a holding register that feeds trace
// memory.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   trace_enable             : tracing on; dropping it flushes and idles
//   atom_valid/atom_data/atom_ready : atom input
//   flush_req, end_req       : single-cycle flush / end-of-test requests
//   frame_valid/frame_ready/frame_buffer/frame_count : frame output
//   dct_buffer, dct_count    : live accumulator
//   test_ending, test_has_ended : end sequence status
//   overflow, overflow_clr   : sticky dropped-atom flag and its clear
//   dbg_state                : current sequencer state
// Handshakes: a transfer happens on every clock edge where valid and ready
// are both high; a valid side never withdraws or changes its payload
// before that edge, and ready may depend combinationally on the consumer.
module cpu0_oci_dct_ctrl
   import cpu0_oci_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = 64,
   parameter int DROP_ON_FULL  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 trace_enable,
   input  logic                 atom_valid,
   input  logic [ATOM_W-1:0]    atom_data,
   output logic                 atom_ready,
   input  logic                 flush_req,
   input  logic                 end_req,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [DCT_BUF_W-1:0] frame_buffer,
   output logic [DCT_CNT_W-1:0] frame_count,
   output logic [DCT_BUF_W-1:0] dct_buffer,
   output logic [DCT_CNT_W-1:0] dct_count,
   output logic                 test_ending,
   output logic                 test_has_ended,
   output logic                 overflow,
   input  logic                 overflow_clr,
   output dct_state_e           dbg_state
);

   localparam int TMO_W = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(FLUSH_TIMEOUT);
   localparam logic [DCT_CNT_W-1:0] CNT_MAX = DCT_CNT_W'(DCT_MAX_ATOMS);

   dct_state_e           state;
   logic [TMO_W-1:0]     tmo_cnt;
   logic                 flush_pend;

   logic                 hold_free;
   logic                 acc_full;
   logic                 accept;
   logic                 tmo_fire;
   logic                 xfer_req;
   logic                 transfer;
   logic                 drop;
   logic [DCT_BUF_W-1:0] pk_buf;
   logic [DCT_CNT_W-1:0] pk_cnt;
   logic [DCT_BUF_W-1:0] acc_buf_nxt;
   logic [DCT_CNT_W-1:0] acc_cnt_nxt;
   dct_frame_t           load_frame;
   dct_frame_t           hold_frame;
   logic                 load_ready;

   assign dbg_state    = state;
   assign frame_buffer = hold_frame.buffer;
   assign frame_count  = hold_frame.count;

   always_comb begin
      hold_free = load_ready;
      acc_full  = (dct_count == CNT_MAX);

      // With a full accumulator an atom is still taken when the holding
      // register frees this cycle: the old 15 leave and the atom starts
      // the next frame. Otherwise it is dropped or backpressured.
      atom_ready = (state == ST_PACK) && trace_enable &&
                   ((DROP_ON_FULL != 0) || !acc_full || hold_free);
      accept     = atom_valid && atom_ready;

      // Atom is packed before any transfer decision so it rides along.
      pk_buf = dct_buffer;
      pk_cnt = dct_count;
      if (accept && !acc_full) begin
         pk_buf = pack_atom(dct_buffer, dct_count, atom_data);
         pk_cnt = dct_count + 4'd1;
      end

      tmo_fire = (FLUSH_TIMEOUT != 0) && (state == ST_PACK) &&
                 (dct_count != '0) && (tmo_cnt == TMO_MAX);

      xfer_req = 1'b0;
      if (state == ST_PACK) begin
         xfer_req = (pk_cnt == CNT_MAX) || flush_req || flush_pend ||
                    tmo_fire || !trace_enable;
      end else if (state == ST_END_FLUSH) begin
         xfer_req = 1'b1;
      end

      // Empty frames are never emitted.
      transfer = xfer_req && hold_free && (pk_cnt != '0);
      drop     = accept && acc_full && !hold_free;

      acc_buf_nxt = pk_buf;
      acc_cnt_nxt = pk_cnt;
      if (transfer) begin
         if (accept && acc_full) begin
            acc_buf_nxt = DCT_BUF_W'(atom_data);
            acc_cnt_nxt = 4'd1;
         end else begin
            acc_buf_nxt = '0;
            acc_cnt_nxt = '0;
         end
      end

      load_frame.count  = pk_cnt;
      load_frame.buffer = pk_buf;
   end

   cpu0_oci_dct_holdreg u_holdreg (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (transfer),
      .load_frame  (load_frame),
      .load_ready  (load_ready),
      .frame_valid (frame_valid),
      .frame       (hold_frame),
      .frame_ready (frame_ready)
   );

   // Accumulator, trigger bookkeeping and sticky flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dct_buffer <= '0;
         dct_count  <= '0;
         tmo_cnt    <= '0;
         flush_pend <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dct_buffer <= acc_buf_nxt;
         dct_count  <= acc_cnt_nxt;

         // Saturating idle counter; once at the limit it keeps requesting
         // the flush until the holding register frees.
         if (state != ST_PACK || accept || dct_count == '0) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         // A flush that cannot be serviced now is remembered.
         if (transfer || state != ST_PACK) begin
            flush_pend <= 1'b0;
         end else if (flush_req && pk_cnt != '0) begin
            flush_pend <= 1'b1;
         end

         // A drop in the same cycle as a clear leaves the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   // Sequencer with registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         test_ending    <= 1'b0;
         test_has_ended <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trace_enable) state <= ST_PACK;
            end
            ST_PACK: begin
               if (end_req) begin
                  state       <= ST_END_FLUSH;
                  test_ending <= 1'b1;
               end else if (!trace_enable && (transfer || pk_cnt == '0)) begin
                  state <= ST_IDLE;
               end
            end
            ST_END_FLUSH: begin
               if (transfer || dct_count == '0) state <= ST_END_DRAIN;
            end
            ST_END_DRAIN: begin
               if (!frame_valid) begin
                  state          <= ST_ENDED;
                  test_ending    <= 1'b0;
                  test_has_ended <= 1'b1;
               end
            end
            ST_ENDED: begin
               state <= ST_ENDED;
            end
            default: begin
               state       <= ST_IDLE;
               test_ending <= 1'b0;
            end
         endcase
      end
   end

endmodule
